// File: rtl/router_ingress_if.sv
// Byte-stream bundle between the packet source, the ingress stage and the output FIFO.
interface router_ingress_if;
   logic [7:0] data_in;
   logic       pkt_valid;
   logic       fifo_full;
   logic       fifo_empty;
   logic       write_enb;
   logic [7:0] data_out;
   logic       lfd_state;
   logic       busy;
   logic       parity_done;
   logic       err;
   logic       len_err;

   // Source and FIFO side (drives the stream, observes the strobes)
   modport master (
      output data_in, pkt_valid, fifo_full, fifo_empty,
      input  write_enb, data_out, lfd_state, busy, parity_done, err, len_err
   );

   // Ingress stage side
   modport slave (
      input  data_in, pkt_valid, fifo_full, fifo_empty,
      output write_enb, data_out, lfd_state, busy, parity_done, err, len_err
   );
endinterface

// File: rtl/router_ingress.sv
// Router ingress stage: takes header/payload/parity bytes from the source, feeds the
// output FIFO through a one-entry hold register, checks parity and packet length.
module router_ingress #(
   parameter bit WAIT_EMPTY_EN = 1'b1
) (
   input logic             i_clock,
   input logic             i_reset,
   input logic             i_soft_reset,
   router_ingress_if.slave io_bus
);

   typedef enum logic [2:0] {
      StIdle      = 3'd0,
      StWaitEmpty = 3'd1,
      StPayload   = 3'd2,
      StParity    = 3'd3,
      StDrain     = 3'd4
   } state_t;

   state_t     r_state;
   logic [7:0] r_hold_data;
   logic       r_hold_lfd;
   logic       r_hold_valid;
   logic [7:0] r_parity;
   logic [5:0] r_remaining;
   logic       r_err;
   logic       r_len_err;
   logic       r_parity_done;

   logic w_busy;
   logic w_write;
   logic w_load;

   // Handshake decode: throttle, FIFO strobe and byte capture
   always_comb begin
      w_busy  = (r_state == StWaitEmpty) | (r_state == StDrain) |
                (r_hold_valid & io_bus.fifo_full);
      // A soft reset discards the held byte, so it must not reach the FIFO that cycle
      w_write = r_hold_valid & ~io_bus.fifo_full & (r_state != StWaitEmpty) & ~i_soft_reset;
      w_load  = 1'b0;
      if (!i_soft_reset && !w_busy) begin
         case (r_state)
            StIdle:    w_load = io_bus.pkt_valid;
            StPayload: w_load = 1'b1;  // low pkt_valid here is an early parity byte
            StParity:  w_load = 1'b1;
            default:   w_load = 1'b0;
         endcase
      end
   end

   // Packet FSM, hold register and parity/length checking
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state       <= StIdle;
         r_hold_data   <= 8'h00;
         r_hold_lfd    <= 1'b0;
         r_hold_valid  <= 1'b0;
         r_parity      <= 8'h00;
         r_remaining   <= 6'd0;
         r_err         <= 1'b0;
         r_len_err     <= 1'b0;
         r_parity_done <= 1'b0;
      end else if (i_soft_reset) begin
         r_state       <= StIdle;
         r_hold_valid  <= 1'b0;
         r_parity      <= 8'h00;
         r_remaining   <= 6'd0;
         r_err         <= 1'b0;
         r_len_err     <= 1'b0;
         r_parity_done <= 1'b0;
      end else begin
         r_parity_done <= 1'b0;

         // A write and a new capture may coincide; the capture wins the valid bit
         if (w_load) begin
            r_hold_data  <= io_bus.data_in;
            r_hold_lfd   <= (r_state == StIdle);
            r_hold_valid <= 1'b1;
         end else if (w_write) begin
            r_hold_valid <= 1'b0;
         end

         case (r_state)
            StIdle: begin
               if (w_load) begin
                  r_parity    <= io_bus.data_in;
                  r_remaining <= io_bus.data_in[7:2];
                  r_err       <= 1'b0;
                  r_len_err   <= 1'b0;
                  if (WAIT_EMPTY_EN && !io_bus.fifo_empty) begin
                     r_state <= StWaitEmpty;
                  end else if (io_bus.data_in[7:2] != 6'd0) begin
                     r_state <= StPayload;
                  end else begin
                     r_state <= StParity;
                  end
               end
            end
            StWaitEmpty: begin
               if (io_bus.fifo_empty) begin
                  r_state <= (r_remaining != 6'd0) ? StPayload : StParity;
               end
            end
            StPayload: begin
               if (w_load) begin
                  if (io_bus.pkt_valid) begin
                     r_parity    <= r_parity ^ io_bus.data_in;
                     r_remaining <= r_remaining - 6'd1;
                     if (r_remaining == 6'd1) begin
                        r_state <= StParity;
                     end
                  end else begin
                     r_err     <= (io_bus.data_in != r_parity);
                     r_len_err <= 1'b1;
                     r_state   <= StDrain;
                  end
               end
            end
            StParity: begin
               if (w_load) begin
                  r_err <= (io_bus.data_in != r_parity);
                  if (io_bus.pkt_valid) begin
                     r_len_err <= 1'b1;  // source still claims payload: packet too long
                  end
                  r_state <= StDrain;
               end
            end
            StDrain: begin
               if (!r_hold_valid) begin
                  r_parity_done <= 1'b1;
                  r_state       <= StIdle;
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign io_bus.write_enb   = w_write;
   assign io_bus.data_out    = r_hold_data;
   assign io_bus.lfd_state   = r_hold_lfd;
   assign io_bus.busy        = w_busy;
   assign io_bus.parity_done = r_parity_done;
   assign io_bus.err         = r_err;
   assign io_bus.len_err     = r_len_err;

endmodule

// File: tb/tb_router_ingress.sv
// Self-checking bench for router_ingress: directed packets, a queue of the bytes the
// FIFO must receive, and packet-level parity/length expectations.
module tb_router_ingress;

   logic clock = 1'b0;
   logic reset;
   logic soft_reset;

   router_ingress_if bus ();

   router_ingress #(.WAIT_EMPTY_EN(1'b1)) dut (
      .i_clock      (clock),
      .i_reset      (reset),
      .i_soft_reset (soft_reset),
      .io_bus       (bus)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [7:0]  data;
      logic        lfd;
      bit          strict;   // FIFO not full and not gated: write must follow accept by 1 cycle
      int unsigned acc;
   } exp_t;

   exp_t        exp_q[$];
   int          errors = 0;
   int          checks = 0;
   int          done_cnt = 0;
   int unsigned cyc = 0;
   logic        exp_err = 1'b0;
   logic        exp_len = 1'b0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   // Packet-level parity: XOR of header and payload bytes
   function automatic logic [7:0] xor4(input logic [7:0] a, b, c, d);
      return a ^ b ^ c ^ d;
   endfunction

   // Per-cycle comparison of everything the FIFO sees against the expected stream
   initial begin : compare
      exp_t e;
      logic prev_done;
      prev_done = 1'b0;
      forever begin
         @(negedge clock);
         if (reset) begin
            prev_done = 1'b0;
         end else begin
            check("write_while_full", {31'd0, bus.write_enb & bus.fifo_full}, 0);
            if (bus.write_enb) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_write", {31'd0, bus.write_enb}, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("write_data", {24'd0, bus.data_out}, {24'd0, e.data});
                  check("write_lfd", {31'd0, bus.lfd_state}, {31'd0, e.lfd});
                  if (e.strict) check("write_latency", cyc - e.acc, 1);
               end
            end
            if (bus.parity_done) begin
               done_cnt++;
               check("done_pulse_width", {31'd0, prev_done}, 0);
               check("err_at_done", {31'd0, bus.err}, {31'd0, exp_err});
               check("len_err_at_done", {31'd0, bus.len_err}, {31'd0, exp_len});
               check("done_queue_empty", exp_q.size(), 0);
            end
            prev_done = bus.parity_done;
         end
      end
   end

   // Present one byte, wait (bounded) for the stage to take it, log it as expected output
   task automatic send(input logic [7:0] d, input logic v, input logic lfd, input bit strict);
      int n;
      n = 0;
      bus.data_in   = d;
      bus.pkt_valid = v;
      @(negedge clock);
      while (bus.busy && n < 200) begin
         @(negedge clock);
         n++;
      end
      if (bus.busy) check("busy_timeout", {31'd0, bus.busy}, 0);
      exp_q.push_back('{data: d, lfd: lfd, strict: strict, acc: cyc});
      @(posedge clock);
      #1;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      bus.pkt_valid = 1'b0;
      while (done_cnt < target && n < 30) begin
         @(negedge clock);
         n++;
      end
      check("parity_done_count", done_cnt, target);
      @(posedge clock);
      #1;
   endtask

   task automatic check_zero_outputs(input string name);
      check({name, "_write_enb"}, {31'd0, bus.write_enb}, 0);
      check({name, "_data_out"}, {24'd0, bus.data_out}, 0);
      check({name, "_lfd"}, {31'd0, bus.lfd_state}, 0);
      check({name, "_busy"}, {31'd0, bus.busy}, 0);
      check({name, "_parity_done"}, {31'd0, bus.parity_done}, 0);
      check({name, "_err"}, {31'd0, bus.err}, 0);
      check({name, "_len_err"}, {31'd0, bus.len_err}, 0);
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      reset          = 1'b1;
      soft_reset     = 1'b0;
      bus.data_in    = 8'h00;
      bus.pkt_valid  = 1'b0;
      bus.fifo_full  = 1'b0;
      bus.fifo_empty = 1'b1;
      #3;
      check_zero_outputs("reset_state");
      @(posedge clock);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // 1: clean packet, one-cycle latency throughout
      exp_err = (8'h0D != xor4(8'h0D, 8'h11, 8'h22, 8'h33));
      exp_len = 1'b0;
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      check("t1_hdr_we", {31'd0, bus.write_enb}, 1);
      check("t1_hdr_data", {24'd0, bus.data_out}, 32'h0D);
      check("t1_hdr_lfd", {31'd0, bus.lfd_state}, 1);
      send(8'h11, 1'b1, 1'b0, 1'b1);
      send(8'h22, 1'b1, 1'b0, 1'b1);
      send(8'h33, 1'b1, 1'b0, 1'b1);
      send(8'h0D, 1'b0, 1'b0, 1'b1);
      wait_done(1);
      check("t1_err", {31'd0, bus.err}, 0);

      // 2: bad parity byte
      exp_err = (8'h0E != xor4(8'h0D, 8'h11, 8'h22, 8'h33));
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      send(8'h11, 1'b1, 1'b0, 1'b1);
      send(8'h22, 1'b1, 1'b0, 1'b1);
      send(8'h33, 1'b1, 1'b0, 1'b1);
      send(8'h0E, 1'b0, 1'b0, 1'b1);
      wait_done(2);
      repeat (3) @(posedge clock);
      #1;
      check("t2_err_held", {31'd0, bus.err}, 1);

      // 3: FIFO not empty at header: stall until it drains
      bus.fifo_empty = 1'b0;
      exp_err = (8'h08 != xor4(8'h09, 8'h0A, 8'h0B, 8'h00));
      send(8'h09, 1'b1, 1'b1, 1'b0);
      check("t3_err_cleared", {31'd0, bus.err}, 0);
      bus.data_in = 8'h0A;
      repeat (3) begin
         @(negedge clock);
         check("t3_busy", {31'd0, bus.busy}, 1);
         check("t3_no_write", {31'd0, bus.write_enb}, 0);
      end
      @(posedge clock);
      #1;
      bus.fifo_empty = 1'b1;
      @(posedge clock);
      #1;
      check("t3_hdr_we", {31'd0, bus.write_enb}, 1);
      check("t3_hdr_data", {24'd0, bus.data_out}, 32'h09);
      send(8'h0A, 1'b1, 1'b0, 1'b1);
      send(8'h0B, 1'b1, 1'b0, 1'b1);
      send(8'h08, 1'b0, 1'b0, 1'b1);
      wait_done(3);

      // 4: FIFO fills while 8'h11 sits in hold
      exp_err = (8'h0D != xor4(8'h0D, 8'h11, 8'h22, 8'h33));
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      send(8'h11, 1'b1, 1'b0, 1'b0);
      bus.fifo_full = 1'b1;
      bus.data_in   = 8'h22;
      repeat (3) begin
         @(negedge clock);
         check("t4_busy", {31'd0, bus.busy}, 1);
         check("t4_no_write", {31'd0, bus.write_enb}, 0);
         check("t4_hold", {24'd0, bus.data_out}, 32'h11);
      end
      @(posedge clock);
      #1;
      bus.fifo_full = 1'b0;
      send(8'h22, 1'b1, 1'b0, 1'b1);
      send(8'h33, 1'b1, 1'b0, 1'b1);
      send(8'h0D, 1'b0, 1'b0, 1'b1);
      wait_done(4);

      // 5: pkt_valid drops after one payload byte; next byte is the parity
      exp_err = (8'h1C != xor4(8'h0D, 8'h11, 8'h00, 8'h00));
      exp_len = 1'b1;
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      send(8'h11, 1'b1, 1'b0, 1'b1);
      send(8'h1C, 1'b0, 1'b0, 1'b1);
      wait_done(5);
      check("t5_len_err", {31'd0, bus.len_err}, 1);
      check("t5_err", {31'd0, bus.err}, 0);

      // 6a: soft reset with a payload byte in hold
      exp_err = 1'b0;
      exp_len = 1'b0;
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      send(8'h11, 1'b1, 1'b0, 1'b1);
      soft_reset    = 1'b1;
      bus.pkt_valid = 1'b0;
      @(negedge clock);
      check("t6_sr_no_write", {31'd0, bus.write_enb}, 0);
      @(posedge clock);
      #1;
      soft_reset = 1'b0;
      exp_q.delete();
      check("t6_sr_len_err", {31'd0, bus.len_err}, 0);
      repeat (3) begin
         @(negedge clock);
         check("t6_sr_idle_write", {31'd0, bus.write_enb}, 0);
         check("t6_sr_idle_busy", {31'd0, bus.busy}, 0);
      end
      @(posedge clock);
      #1;
      exp_err = (8'h41 != xor4(8'h05, 8'h44, 8'h00, 8'h00));
      send(8'h05, 1'b1, 1'b1, 1'b1);
      send(8'h44, 1'b1, 1'b0, 1'b1);
      send(8'h41, 1'b0, 1'b0, 1'b1);
      wait_done(6);

      // 6b: async reset mid-packet clears outputs before the next edge
      send(8'h0D, 1'b1, 1'b1, 1'b1);
      send(8'h11, 1'b1, 1'b0, 1'b1);
      bus.pkt_valid = 1'b0;
      #1;
      reset = 1'b1;
      #1;
      check_zero_outputs("async_reset");
      exp_q.delete();
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;

      // Zero-length packet after reset recovery
      exp_err = 1'b0;
      exp_len = 1'b0;
      send(8'h02, 1'b1, 1'b1, 1'b1);
      send(8'h02, 1'b0, 1'b0, 1'b1);
      wait_done(7);
      check("final_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/router_ingress.md
Name: router_ingress

Overview:
- Packet ingress stage of the 1x3 router. It sits directly upstream of the per-port output FIFO.
- Accepts the source byte stream (header, payload, parity), generates the FIFO write strobe and the header flag (lfd_state), and throttles the source with busy.
- Computes running XOR parity and checks the trailing parity byte; also detects packets that end early.
- A one-entry hold register absorbs a byte when the FIFO is full.

Parameters:
- WAIT_EMPTY_EN, 1: when 1, the header is not written until fifo_empty=1; when 0, the header is written immediately.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state
- soft_reset  input  1  synchronous abort of the current packet
- data_in  input  8  source byte
- pkt_valid  input  1  high during header and payload bytes; low during the parity byte
- fifo_full  input  1  from the downstream FIFO
- fifo_empty  input  1  from the downstream FIFO
- write_enb  output  1  FIFO write strobe
- data_out  output  8  byte to the FIFO
- lfd_state  output  1  marks data_out as a header byte
- busy  output  1  source must hold data_in while busy=1
- parity_done  output  1  one-cycle pulse when the packet completes
- err  output  1  parity mismatch, valid from parity_done
- len_err  output  1  packet ended before the header length was reached

Behaviour:
- Packet format:
  - header[7:2] = payload length L (0..63); header[1:0] = address (carried, not decoded).
  - Then L payload bytes, then 1 parity byte.
  - Parity byte = XOR of header and all payload bytes.
- Hold register: hold_data[7:0], hold_lfd, hold_valid.
  - data_out = hold_data; lfd_state = hold_lfd.
  - write_enb = hold_valid & ~fifo_full & (state != WAIT_EMPTY).
  - hold_valid clears on a write unless a new byte is accepted in the same cycle (simultaneous write plus accept is legal).
- busy = (state==WAIT_EMPTY) | (state==DRAIN) | (hold_valid & fifo_full).
  - accept = ~busy & (condition given per state below).
  - FIFO write occurs no earlier than 1 cycle after accept. Latency is exactly 1 cycle when the FIFO is not full.
- State machine (3-bit): IDLE, WAIT_EMPTY, PAYLOAD, PARITY, DRAIN.
  - IDLE, accept on pkt_valid:
    - Load hold with lfd=1; parity_reg<=data_in; remaining<=data_in[7:2]; clear err and len_err.
    - Next state: WAIT_EMPTY if WAIT_EMPTY_EN & ~fifo_empty; else PAYLOAD if L>0; else PARITY.
  - WAIT_EMPTY: on fifo_empty=1, go to PAYLOAD (L>0) or PARITY (L=0). The header writes on the following cycle.
  - PAYLOAD, accept on pkt_valid:
    - Load hold with lfd=0; parity_reg^=data_in; remaining-=1.
    - When remaining reaches 0, go to PARITY.
  - PAYLOAD, ~pkt_valid & ~busy: early end.
    - data_in is taken as the parity byte: written to the FIFO and compared.
    - len_err<=1; go to DRAIN.
  - PARITY, accept regardless of pkt_valid:
    - Load hold with lfd=0.
    - err<=(data_in != parity_reg); go to DRAIN.
    - If pkt_valid=1 here, len_err<=1 (packet longer than its header).
  - DRAIN: when hold_valid=0 (parity byte written), pulse parity_done for 1 cycle and go to IDLE.
  - err and len_err hold until the next header accept.
- remaining is 6-bit; the decrement never wraps because PARITY is entered at 0.
- soft_reset (sync, priority over everything except reset):
  - state<=IDLE; hold_valid<=0 (held byte discarded, not written).
  - Counters cleared; err and len_err cleared.
- reset (async, mid-operation):
  - Everything cleared immediately: state IDLE; data_out 8'h00; write_enb 0; lfd_state 0; busy 0; parity_done 0; err 0; len_err 0.
  - The partial packet is lost.
- fifo_full asserting while the hold register is occupied: the byte stays in hold, busy rises the same cycle, and no byte is dropped or duplicated.

Test Plan:
1. Empty FIFO, header 8'h0D, payload 8'h11/8'h22/8'h33, parity 8'h0D (pkt_valid low) -> writes 0D (lfd=1), 11, 22, 33, 0D on consecutive cycles, each 1 cycle after accept; parity_done pulses; err=0; len_err=0.
2. Same packet with parity 8'h0E -> all 5 bytes written; err=1 at parity_done and held until the next header.
3. fifo_empty=0 at header 8'h09 -> busy=1 and no write until fifo_empty=1; header written the cycle after.
4. fifo_full raised after 8'h11 is held -> busy=1, write_enb=0, data_out stays 8'h11; releasing full writes 11 once, then the stream resumes with no loss.
5. Header 8'h0D with pkt_valid dropped after 1 payload byte (8'h11), next byte 8'h1C -> 1C written as parity; len_err=1; err=0; parity_done pulses; return to IDLE.
6. soft_reset during PAYLOAD with a byte in hold -> no further write_enb; state IDLE; a new header 8'h05 processes normally. Async reset mid-packet -> all outputs 0 within the same cycle.
